// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: one FSM steps fetch/decode/execute/memory/write-back over a shared ALU and memory port.
// Latency: 3 cycles (branch/jump), 4 (R-type/imm), 4 (sw), 5 (lw) plus any memory wait cycles.
// Backpressure: FETCH, MEM_RD and MEM_WR hold with mem_req_o stable until mem_ready_i; no other stall.
// Optional build macro MIPS_MC_ILLEGAL_TRAP_EN: unknown opcodes park in TRAP (illegal_o=1) until reset.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32,
  parameter int OP_W  = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [OP_W-1:0]  instr_op_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             iord_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic [1:0]       pc_src_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             zero_extend_o,
  output logic             lui_ctrl_o,
  output logic             sltiu_ctrl_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instret_o,
  output logic             illegal_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_I     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'b001111);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(6'b001011);

  state_t           state_q, state_n;
  logic [CNT_W-1:0] instret_q;

  // State register; reset drops any in-flight access and returns to FETCH
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_n;
  end

  // Retired-instruction counter: one count per return to FETCH (free-running wrap)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                       instret_q <= '0;
    else if (state_q != S_FETCH && state_n == S_FETCH) instret_q <= instret_q + CNT_W'(1);
  end

  // Next-state and state-decoded datapath controls
  always_comb begin
    state_n       = state_q;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    iord_o        = 1'b0;
    ir_write_o    = 1'b0;
    pc_write_o    = 1'b0;
    pc_src_o      = 2'b00;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = 2'b00;
    alu_op_o      = 3'b000;
    reg_write_o   = 1'b0;
    reg_dst_o     = 1'b0;
    mem_to_reg_o  = 1'b0;
    zero_extend_o = 1'b0;
    lui_ctrl_o    = 1'b0;
    sltiu_ctrl_o  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = 2'b01;
        alu_op_o    = 3'b001;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_n    = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut captures PC+4 + (imm<<2) as a speculative branch target
        alu_src_b_o = 2'b11;
        alu_op_o    = 3'b001;
        case (instr_op_i)
          OP_RTYPE:                           state_n = S_EXEC_R;
          OP_LW, OP_SW:                       state_n = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                     state_n = S_BRANCH;
          OP_J:                               state_n = S_JUMP;
          OP_ADDI, OP_LUI, OP_ORI, OP_SLTIU:  state_n = S_EXEC_I;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
          default:                            state_n = S_TRAP;
`else
          default:                            state_n = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        state_n     = S_WB_R;
      end
      S_WB_R: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        state_n     = S_FETCH;
      end
      S_EXEC_I, S_WB_I: begin
        // Immediate-op selects stay up through write-back so the ALU result is stable
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        case (instr_op_i)
          OP_LUI:   begin alu_op_o = 3'b100; lui_ctrl_o = 1'b1; end
          OP_ORI:   begin alu_op_o = 3'b101; zero_extend_o = 1'b1; end
          OP_SLTIU: begin alu_op_o = 3'b110; zero_extend_o = 1'b1; sltiu_ctrl_o = 1'b1; end
          default:  alu_op_o = 3'b001;
        endcase
        if (state_q == S_WB_I) begin
          reg_write_o = 1'b1;
          state_n     = S_FETCH;
        end else begin
          state_n     = S_WB_I;
        end
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = 3'b001;
        state_n     = (instr_op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        if (mem_ready_i) state_n = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        state_n      = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        iord_o    = 1'b1;
        if (mem_ready_i) state_n = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        pc_src_o    = 2'b01;
        if (instr_op_i == OP_BNE) begin
          alu_op_o   = 3'b011;
          pc_write_o = !zero_i;
        end else begin
          alu_op_o   = 3'b010;
          pc_write_o = zero_i;
        end
        state_n = S_FETCH;
      end
      S_JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = 2'b10;
        state_n    = S_FETCH;
      end
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
      S_TRAP:  state_n = S_TRAP;
`endif
      default: state_n = S_FETCH;
    endcase
  end

  assign state_o   = state_q;
  assign instret_o = instret_q;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
  assign illegal_o = (state_q == S_TRAP);
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multi-cycle sequencer: per-cycle expected control words are queued and compared.
// Built with a 4-bit retired-instruction counter so the wrap can be reached in a few hundred cycles.
// Illegal-opcode step follows whichever build of MIPS_MC_ILLEGAL_TRAP_EN is compiled.
module tb_mips_multicycle_ctrl;
  localparam int CW = 4;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3,
                         S_MEM_WB = 4'd4, S_MEM_WR = 4'd5, S_EXEC_R = 4'd6, S_WB_R = 4'd7,
                         S_EXEC_I = 4'd8, S_WB_I = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11,
                         S_TRAP = 4'd12;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010,
                         OP_ADDI = 6'b001000, OP_LUI = 6'b001111, OP_ORI = 6'b001101,
                         OP_SLTIU = 6'b001011, OP_BAD = 6'b111111;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [5:0]    instr_op_i;
  logic          zero_i;
  logic          mem_ready_i;
  logic          mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o;
  logic [1:0]    pc_src_o;
  logic          alu_src_a_o;
  logic [1:0]    alu_src_b_o;
  logic [2:0]    alu_op_o;
  logic          reg_write_o, reg_dst_o, mem_to_reg_o, zero_extend_o, lui_ctrl_o, sltiu_ctrl_o;
  logic [3:0]    state_o;
  logic [CW-1:0] instret_o;
  logic          illegal_o;

  mips_multicycle_ctrl #(.CNT_W(CW), .OP_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .iord_o(iord_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .zero_extend_o(zero_extend_o), .lui_ctrl_o(lui_ctrl_o), .sltiu_ctrl_o(sltiu_ctrl_o),
    .state_o(state_o), .instret_o(instret_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]    st;
    logic          mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0]    pc_src;
    logic          src_a;
    logic [1:0]    src_b;
    logic [2:0]    op;
    logic          reg_write, reg_dst, mem_to_reg, ze, lui, sltiu, illegal;
    logic [CW-1:0] cnt;
  } ctl_t;

  ctl_t          exp_q[$];
  string         tag_q[$];
  int            tests = 0;
  int            failed = 0;
  logic [CW-1:0] exp_cnt = '0;

  // Expected control word for a given state, written from the per-state output table
  function automatic ctl_t exp_of(logic [3:0] st, logic [5:0] op, logic z, logic rdy);
    ctl_t e;
    e = '0;
    e.st  = st;
    e.cnt = exp_cnt;
    case (st)
      S_FETCH:    begin e.mem_req = 1; e.src_b = 2'b01; e.op = 3'b001; e.ir_write = rdy; e.pc_write = rdy; end
      S_DECODE:   begin e.src_b = 2'b11; e.op = 3'b001; end
      S_EXEC_R:   begin e.src_a = 1; end
      S_WB_R:     begin e.reg_write = 1; e.reg_dst = 1; end
      S_EXEC_I, S_WB_I: begin
        e.src_a = 1; e.src_b = 2'b10; e.reg_write = (st == S_WB_I);
        case (op)
          OP_LUI:   begin e.op = 3'b100; e.lui = 1; end
          OP_ORI:   begin e.op = 3'b101; e.ze = 1; end
          OP_SLTIU: begin e.op = 3'b110; e.ze = 1; e.sltiu = 1; end
          default:  e.op = 3'b001;
        endcase
      end
      S_MEM_ADDR: begin e.src_a = 1; e.src_b = 2'b10; e.op = 3'b001; end
      S_MEM_RD:   begin e.mem_req = 1; e.iord = 1; end
      S_MEM_WB:   begin e.reg_write = 1; e.mem_to_reg = 1; end
      S_MEM_WR:   begin e.mem_req = 1; e.mem_we = 1; e.iord = 1; end
      S_BRANCH: begin
        e.src_a = 1; e.pc_src = 2'b01;
        if (op == OP_BNE) begin e.op = 3'b011; e.pc_write = !z; end
        else              begin e.op = 3'b010; e.pc_write = z;  end
      end
      S_JUMP:     begin e.pc_write = 1; e.pc_src = 2'b10; end
      S_TRAP:     begin e.illegal = 1; end
      default:    ;
    endcase
    return e;
  endfunction

  function automatic ctl_t observed();
    return '{state_o, mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o, alu_src_a_o,
             alu_src_b_o, alu_op_o, reg_write_o, reg_dst_o, mem_to_reg_o, zero_extend_o,
             lui_ctrl_o, sltiu_ctrl_o, illegal_o, instret_o};
  endfunction

  // Pop the oldest expectation and compare it with the DUT outputs
  task automatic chk();
    ctl_t  e;
    ctl_t  o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = observed();
    tests++;
    assert (o === e) else begin
      failed++;
      $error("FAIL %s: observed=%h expected=%h (state %0d vs %0d, instret %0d vs %0d)",
             t, o, e, o.st, e.st, o.cnt, e.cnt);
    end
  endtask

  // One clock: drive inputs just after the edge, queue the expectation, compare on the falling edge
  task automatic cyc(string tag, logic [3:0] st, logic [5:0] op, logic z, logic rdy);
    @(posedge clk_i);
    #1;
    instr_op_i  = op;
    zero_i      = z;
    mem_ready_i = rdy;
    exp_q.push_back(exp_of(st, op, z, rdy));
    tag_q.push_back(tag);
    @(negedge clk_i);
    chk();
  endtask

  // Assert reset mid-cycle and expect an immediate return to FETCH with a cleared counter
  task automatic reset_now(string tag);
    @(posedge clk_i);
    #1;
    rst_i       = 1'b1;
    mem_ready_i = 1'b0;
    exp_cnt     = '0;
    exp_q.push_back(exp_of(S_FETCH, instr_op_i, 1'b0, 1'b0));
    tag_q.push_back(tag);
    @(negedge clk_i);
    chk();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; instr_op_i = OP_R; zero_i = 1'b0; mem_ready_i = 1'b0;
    exp_q.push_back(exp_of(S_FETCH, OP_R, 1'b0, 1'b0));
    tag_q.push_back("reset");
    @(negedge clk_i);
    chk();
    rst_i = 1'b0;

    // addi with memory always ready: four cycles, counter 0 -> 1
    cyc("addi_f", S_FETCH, OP_ADDI, 0, 1);
    cyc("addi_d", S_DECODE, OP_ADDI, 0, 1);
    cyc("addi_x", S_EXEC_I, OP_ADDI, 0, 1);
    cyc("addi_w", S_WB_I, OP_ADDI, 0, 1);
    exp_cnt++;

    // lw: fetch waits 3 cycles, data waits 2
    for (int i = 0; i < 3; i++) cyc("lw_fwait", S_FETCH, OP_LW, 0, 0);
    cyc("lw_f", S_FETCH, OP_LW, 0, 1);
    cyc("lw_d", S_DECODE, OP_LW, 0, 1);
    cyc("lw_a", S_MEM_ADDR, OP_LW, 0, 1);
    for (int i = 0; i < 2; i++) cyc("lw_rwait", S_MEM_RD, OP_LW, 0, 0);
    cyc("lw_r", S_MEM_RD, OP_LW, 0, 1);
    cyc("lw_wb", S_MEM_WB, OP_LW, 0, 1);
    exp_cnt++;

    // sw with one write wait cycle; ready during MEM_ADDR must be ignored
    cyc("sw_f", S_FETCH, OP_SW, 0, 1);
    cyc("sw_d", S_DECODE, OP_SW, 0, 0);
    cyc("sw_a", S_MEM_ADDR, OP_SW, 0, 1);
    cyc("sw_wait", S_MEM_WR, OP_SW, 0, 0);
    cyc("sw_w", S_MEM_WR, OP_SW, 0, 1);
    exp_cnt++;

    // R-type
    cyc("r_f", S_FETCH, OP_R, 0, 1);
    cyc("r_d", S_DECODE, OP_R, 0, 1);
    cyc("r_x", S_EXEC_R, OP_R, 0, 1);
    cyc("r_w", S_WB_R, OP_R, 0, 1);
    exp_cnt++;

    // Branches: beq taken, bne with zero set not taken, bne with zero clear taken
    cyc("beq_f", S_FETCH, OP_BEQ, 1, 1);
    cyc("beq_d", S_DECODE, OP_BEQ, 1, 1);
    cyc("beq_b", S_BRANCH, OP_BEQ, 1, 1);
    exp_cnt++;
    cyc("bne1_f", S_FETCH, OP_BNE, 1, 1);
    cyc("bne1_d", S_DECODE, OP_BNE, 1, 1);
    cyc("bne1_b", S_BRANCH, OP_BNE, 1, 1);
    exp_cnt++;
    cyc("bne0_f", S_FETCH, OP_BNE, 0, 1);
    cyc("bne0_d", S_DECODE, OP_BNE, 0, 1);
    cyc("bne0_b", S_BRANCH, OP_BNE, 0, 1);
    exp_cnt++;

    // ori then sltiu back to back, then lui
    cyc("ori_f", S_FETCH, OP_ORI, 0, 1);
    cyc("ori_d", S_DECODE, OP_ORI, 0, 1);
    cyc("ori_x", S_EXEC_I, OP_ORI, 0, 1);
    cyc("ori_w", S_WB_I, OP_ORI, 0, 1);
    exp_cnt++;
    cyc("sltiu_f", S_FETCH, OP_SLTIU, 0, 1);
    cyc("sltiu_d", S_DECODE, OP_SLTIU, 0, 1);
    cyc("sltiu_x", S_EXEC_I, OP_SLTIU, 0, 1);
    cyc("sltiu_w", S_WB_I, OP_SLTIU, 0, 1);
    exp_cnt++;
    cyc("lui_f", S_FETCH, OP_LUI, 0, 1);
    cyc("lui_d", S_DECODE, OP_LUI, 0, 1);
    cyc("lui_x", S_EXEC_I, OP_LUI, 0, 1);
    cyc("lui_w", S_WB_I, OP_LUI, 0, 1);
    exp_cnt++;

    // Jump
    cyc("j_f", S_FETCH, OP_J, 0, 1);
    cyc("j_d", S_DECODE, OP_J, 0, 1);
    cyc("j_j", S_JUMP, OP_J, 0, 1);
    exp_cnt++;

    // Reset while waiting on a load
    cyc("rst_f", S_FETCH, OP_LW, 0, 1);
    cyc("rst_d", S_DECODE, OP_LW, 0, 1);
    cyc("rst_a", S_MEM_ADDR, OP_LW, 0, 1);
    cyc("rst_rwait", S_MEM_RD, OP_LW, 0, 0);
    reset_now("rst_mid_load");
    cyc("rst_after", S_FETCH, OP_J, 0, 0);

    // Counter wrap: 17 jumps from zero pass through 2^CW-1 -> 0
    for (int i = 0; i < 17; i++) begin
      cyc("wrap_f", S_FETCH, OP_J, 0, 1);
      cyc("wrap_d", S_DECODE, OP_J, 0, 1);
      cyc("wrap_j", S_JUMP, OP_J, 0, 1);
      exp_cnt++;
    end

    // Unknown opcode
    cyc("bad_f", S_FETCH, OP_BAD, 0, 1);
    cyc("bad_d", S_DECODE, OP_BAD, 0, 1);
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) cyc("bad_trap", S_TRAP, OP_BAD, 0, 1);
    reset_now("bad_reset");
`else
    exp_cnt++;
    cyc("bad_nop", S_FETCH, OP_BAD, 0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
